// File: rtl/flash_led_monitor.sv
// Tracks a rotating LED run pattern, recovers its lit width and direction, and flags inconsistent steps.
// Optional saturating error counter is built only when FLASH_LED_MONITOR_ERRCNT_EN is defined.
module flash_led_monitor #(
    parameter int LOCK_STEPS = 3,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CLK_BPS,
    input  logic [LED_W-1:0] led,
    output logic [3:0]       width,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

    function automatic logic [7:0] popcount(input logic [LED_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < LED_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // A contiguous run (with wrap) has at most one cyclic 0->1 boundary.
    function automatic logic [7:0] rise_count(input logic [LED_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < LED_W; i++) begin
            n = n + {7'd0, v[i] & ~v[(i + LED_W - 1) % LED_W]};
        end
        return n;
    endfunction

    function automatic logic [LED_W-1:0] rot_l(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

    function automatic logic [LED_W-1:0] rot_r(input logic [LED_W-1:0] v);
        return {v[0], v[LED_W-1:1]};
    endfunction

    state_t           state;
    logic [LED_W-1:0] prev;
    logic [3:0]       run_cnt;
    logic             trk_dir;
    logic             bps_q;

    logic             step;
    logic [7:0]       cur_pc;
    logic [7:0]       prev_pc;
    logic             is_left;
    logic             is_right;
    logic             is_static;
    logic             cur_valid;
    logic             consistent;
    logic             step_dir;
    logic             lock_ok;
    logic             dir_change;
    logic [3:0]       next_cnt;
    logic             err_set;

    // Step strobe: one step per rising edge of CLK_BPS; led is sampled only on that cycle, a held-high strobe is a single step.
    assign step      = CLK_BPS & ~bps_q;
    assign fsm_state = state;

    always_comb begin
        cur_pc     = popcount(led);
        prev_pc    = popcount(prev);
        is_left    = (led == rot_l(prev));
        is_right   = (led == rot_r(prev));
        is_static  = (led == prev) && (cur_pc == 8'd0);
        cur_valid  = (cur_pc <= 8'd8) && (rise_count(led) <= 8'd1);
        consistent = cur_valid && (cur_pc == prev_pc) && (is_left || is_right || is_static);
        step_dir   = ~is_left;
        // Static (all-off) steps carry no direction, so they never break a direction run.
        lock_ok    = consistent && (cur_pc == {4'd0, width}) && (is_static || (step_dir == dir));
        dir_change = (run_cnt != 4'd0) && !is_static && (step_dir != trk_dir);
        next_cnt   = dir_change ? 4'd1 : run_cnt + 4'd1;
        err_set    = step && (((state == ACQ)    && !consistent) ||
                              ((state == LOCKED) && !lock_ok)    ||
                              ((state == FAULT)  && !consistent));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prev    <= '0;
            run_cnt <= '0;
            trk_dir <= 1'b0;
            bps_q   <= 1'b0;
            width   <= '0;
            dir     <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            bps_q <= CLK_BPS;
            err   <= err_set;
            if (step) begin
                prev <= led;
                case (state)
                    IDLE: begin
                        state   <= ACQ;
                        run_cnt <= '0;
                    end
                    ACQ: begin
                        if (consistent) begin
                            run_cnt <= next_cnt;
                            if (!is_static) trk_dir <= step_dir;
                            if (next_cnt >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                width  <= cur_pc[3:0];
                                if (!is_static) dir <= step_dir;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!lock_ok) begin
                            state  <= FAULT;
                            locked <= 1'b0;
                        end
                    end
                    FAULT: begin
                        if (consistent) begin
                            state   <= ACQ;
                            run_cnt <= 4'd1;
                            if (!is_static) trk_dir <= step_dir;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FLASH_LED_MONITOR_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_set && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
